// File: rtl/cpu_pkg.sv
// Shared definitions for the sequencer CPU: instruction layout, opcodes and FSM states.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 4;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LOADI = 4'h1,
        OP_MOVE  = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_XOR   = 4'h7,
        OP_JUMP  = 4'h8,
        OP_JZ    = 4'h9,
        OP_JC    = 4'hA,
        OP_RESET = 4'hB,
        OP_HALT  = 4'hC,
        OP_RSVD  = 4'hD,
        OP_RSVE  = 4'hE,
        OP_RSVF  = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXECUTE = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the register/register opcodes; carry doubles as borrow on SUB.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  opcode_t               opcode,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry,
    output logic                  zero
);

    logic [DATA_WIDTH:0] wide;

    // One extra bit catches carry out of ADD and the borrow of SUB (a<b).
    always_comb begin
        wide = '0;
        case (opcode)
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            default: wide = '0;
        endcase
    end

    assign result = wide[DATA_WIDTH-1:0];
    assign carry  = wide[DATA_WIDTH];
    assign zero   = (result == '0);

endmodule

// File: rtl/sequencer_cpu.sv
// Multi-cycle register-file CPU: FETCH over a valid handshake, EXECUTE one opcode, optional HALT.
module sequencer_cpu
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PC_WIDTH   = 8,
    parameter int NUM_REGS   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_valid,
    input  logic [INSTR_W-1:0]    imem_data,
    input  logic                  start,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [DATA_WIDTH-1:0] accumulator,
    output logic                  zero_flag,
    output logic                  carry_flag,
    output logic                  halted,
    output logic                  retired
);

    localparam int IDX_W = $clog2(NUM_REGS);

    state_t                state;
    state_t                state_next;
    logic [INSTR_W-1:0]    ir;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    opcode_t               opc;
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      rs_idx;
    logic [IMM_W-1:0]      imm;
    logic [PC_WIDTH-1:0]   pc_inc;
    logic [PC_WIDTH-1:0]   jump_target;

    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_carry;
    logic                  alu_zero;

    assign opc         = opcode_t'(ir[OPC_MSB:OPC_LSB]);
    // Truncating cast keeps only the low index bits; upper field bits are don't-care.
    assign rd_idx      = IDX_W'(ir[RD_MSB:RD_LSB]);
    assign rs_idx      = IDX_W'(ir[RS_MSB:RS_LSB]);
    assign imm         = ir[IMM_MSB:IMM_LSB];
    assign pc_inc      = pc + PC_WIDTH'(1);
    assign jump_target = imm[PC_WIDTH-1:0];

    cpu_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .a      (regs[rd_idx]),
        .b      (regs[rs_idx]),
        .opcode (opc),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH:   if (imem_valid) state_next = ST_EXECUTE;
            ST_EXECUTE: state_next = (opc == OP_HALT) ? ST_HALTED : ST_FETCH;
            ST_HALTED:  if (start) state_next = ST_FETCH;
            default:    state_next = ST_FETCH;
        endcase
    end

    // Reset drops the state to FETCH immediately, so the request must also be gated by reset itself.
    assign imem_req    = (state == ST_FETCH) && !reset;
    assign imem_addr   = pc;
    assign halted      = (state == ST_HALTED);
    assign retired     = (state == ST_EXECUTE);
    assign accumulator = regs[0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc         <= '0;
            ir         <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if ((state == ST_FETCH) && imem_valid) begin
                ir <= imem_data;
            end
            if (state == ST_EXECUTE) begin
                pc <= pc_inc;
                case (opc)
                    OP_LOADI: regs[rd_idx] <= DATA_WIDTH'(imm);
                    OP_MOVE:  regs[rd_idx] <= regs[rs_idx];
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        regs[rd_idx] <= alu_result;
                        zero_flag    <= alu_zero;
                        carry_flag   <= alu_carry;
                    end
                    OP_JUMP:  pc <= jump_target;
                    OP_JZ:    if (zero_flag) pc <= jump_target;
                    OP_JC:    if (carry_flag) pc <= jump_target;
                    OP_RESET: begin
                        pc         <= '0;
                        zero_flag  <= 1'b0;
                        carry_flag <= 1'b0;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            regs[i] <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
